// File: rtl/medikit_pkg.sv
// Shared medicine-kit definitions: the 4-bit scheduler state codes, which the
// buzzer driver also decodes, and a saturating counter helper.
package medikit_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'b0000;
    localparam state_t ST_COUNTDOWN = 4'b0001;
    localparam state_t ST_TAKEN     = 4'b0010;
    localparam state_t ST_ALARM_1   = 4'b0110;
    localparam state_t ST_ALARM_2   = 4'b0111;
    localparam state_t ST_ALARM_3   = 4'b1000;
    localparam state_t ST_MISSED    = 4'b1001;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector for a synchronised button level. The history register
// resets high so that a button held through reset release is not seen as a press.
module rise_edge (
    input  logic clk_base,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_edge
);

    logic r_btn_q;

    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) r_btn_q <= 1'b1;
        else        r_btn_q <= i_btn;
    end

    assign o_edge = i_btn & ~r_btn_q;

endmodule

// File: rtl/dose_scheduler.sv
// Dose reminder FSM: counts down the dose interval on a 1 Hz tick, escalates
// through three alarm levels, and tallies taken and missed doses.
module dose_scheduler
    import medikit_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int ALARM_T = 60,
    parameter int HOLD_T  = 5
) (
    input  logic             clk_base,
    input  logic             rst_n,
    input  logic             tick_1hz,
    input  logic             arm_btn,
    input  logic             ack_btn,
    input  logic             cancel_btn,
    input  logic [CNT_W-1:0] interval,
    output logic [3:0]       state_out,
    output logic [CNT_W-1:0] remain,
    output logic [7:0]       taken_cnt,
    output logic [7:0]       missed_cnt
);

    localparam int PH_MAX = (ALARM_T > HOLD_T) ? ALARM_T : HOLD_T;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0]  PH_ALARM = PH_W'(ALARM_T);
    localparam logic [PH_W-1:0]  PH_HOLD  = PH_W'(HOLD_T);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic w_arm, w_ack, w_cancel;

    state_t           r_state;
    logic [CNT_W-1:0] r_remain;
    logic [CNT_W-1:0] r_interval;
    logic [PH_W-1:0]  r_phase;
    logic [7:0]       r_taken;
    logic [7:0]       r_missed;

    rise_edge u_arm_edge (
        .clk_base (clk_base),
        .rst_n    (rst_n),
        .i_btn    (arm_btn),
        .o_edge   (w_arm)
    );

    rise_edge u_ack_edge (
        .clk_base (clk_base),
        .rst_n    (rst_n),
        .i_btn    (ack_btn),
        .o_edge   (w_ack)
    );

    rise_edge u_cancel_edge (
        .clk_base (clk_base),
        .rst_n    (rst_n),
        .i_btn    (cancel_btn),
        .o_edge   (w_cancel)
    );

    // Priority inside a cycle is cancel > ack > tick; an ack that wins during
    // an alarm leaves the phase untouched by the concurrent tick.
    always_ff @(posedge clk_base or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_remain   <= '0;
            r_interval <= '0;
            r_phase    <= '0;
            r_taken    <= '0;
            r_missed   <= '0;
        end else if (w_cancel) begin
            r_state  <= ST_IDLE;
            r_remain <= '0;
            r_phase  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arm && (interval != '0)) begin
                        r_interval <= interval;
                        r_remain   <= interval;
                        r_state    <= ST_COUNTDOWN;
                    end
                end
                ST_COUNTDOWN: begin
                    if (tick_1hz) begin
                        if (r_remain <= CNT_ONE) begin
                            r_remain <= '0;
                            r_phase  <= PH_ALARM;
                            r_state  <= ST_ALARM_1;
                        end else begin
                            r_remain <= r_remain - CNT_ONE;
                        end
                    end
                end
                ST_ALARM_1, ST_ALARM_2, ST_ALARM_3: begin
                    if (w_ack) begin
                        r_taken <= sat_inc8(r_taken);
                        r_phase <= PH_HOLD;
                        r_state <= ST_TAKEN;
                    end else if (tick_1hz) begin
                        if (r_phase <= PH_ONE) begin
                            if (r_state == ST_ALARM_3) begin
                                r_missed <= sat_inc8(r_missed);
                                r_phase  <= PH_HOLD;
                                r_state  <= ST_MISSED;
                            end else begin
                                r_phase <= PH_ALARM;
                                r_state <= (r_state == ST_ALARM_1) ? ST_ALARM_2 : ST_ALARM_3;
                            end
                        end else begin
                            r_phase <= r_phase - PH_ONE;
                        end
                    end
                end
                ST_TAKEN, ST_MISSED: begin
                    // An ack in MISSED skips the remaining hold time.
                    if ((w_ack && (r_state == ST_MISSED)) ||
                        (tick_1hz && (r_phase <= PH_ONE))) begin
                        r_remain <= r_interval;
                        r_phase  <= '0;
                        r_state  <= ST_COUNTDOWN;
                    end else if (tick_1hz) begin
                        r_phase <= r_phase - PH_ONE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_remain <= '0;
                    r_phase  <= '0;
                end
            endcase
        end
    end

    assign state_out  = r_state;
    assign remain     = r_remain;
    assign taken_cnt  = r_taken;
    assign missed_cnt = r_missed;

endmodule

// File: tb/tb_dose_scheduler.sv
// Directed bench for dose_scheduler with ALARM_T = 4, HOLD_T = 5.
module tb_dose_scheduler;

    logic        clk_base;
    logic        rst_n;
    logic        tick_1hz;
    logic        arm_btn;
    logic        ack_btn;
    logic        cancel_btn;
    logic [15:0] interval;
    logic [3:0]  state_out;
    logic [15:0] remain;
    logic [7:0]  taken_cnt;
    logic [7:0]  missed_cnt;

    int vectors;
    int miscompares;

    dose_scheduler #(.CNT_W(16), .ALARM_T(4), .HOLD_T(5)) dut (
        .clk_base   (clk_base),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .arm_btn    (arm_btn),
        .ack_btn    (ack_btn),
        .cancel_btn (cancel_btn),
        .interval   (interval),
        .state_out  (state_out),
        .remain     (remain),
        .taken_cnt  (taken_cnt),
        .missed_cnt (missed_cnt)
    );

    initial clk_base = 1'b0;
    always #5 clk_base = ~clk_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs high, then everything released.
    task automatic step(input logic t, input logic a, input logic k, input logic c);
        @(negedge clk_base);
        tick_1hz = t; arm_btn = a; ack_btn = k; cancel_btn = c;
        @(negedge clk_base);
        tick_1hz = 0; arm_btn = 0; ack_btn = 0; cancel_btn = 0;
    endtask

    task automatic tick();
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 0; tick_1hz = 0; arm_btn = 1; ack_btn = 0; cancel_btn = 0;
        interval = 16'd3;
        repeat (3) @(negedge clk_base);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_remain", 32'(remain), 32'd0);
        chk("rst_taken", 32'(taken_cnt), 32'd0);
        chk("rst_missed", 32'(missed_cnt), 32'd0);

        // arm held through reset release must not arm
        rst_n = 1;
        repeat (3) @(negedge clk_base);
        chk("held_arm_no_edge", 32'(state_out), 32'd0);
        arm_btn = 0;
        @(negedge clk_base);

        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("arm_state", 32'(state_out), 32'd1);
        chk("arm_remain", 32'(remain), 32'd3);

        // arm and ack are both ignored while counting down
        interval = 16'd7;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("arm_ign_state", 32'(state_out), 32'd1);
        chk("arm_ign_remain", 32'(remain), 32'd3);
        chk("ack_ign_taken", 32'(taken_cnt), 32'd0);

        tick();
        chk("cd_remain2", 32'(remain), 32'd2);
        tick();
        chk("cd_remain1", 32'(remain), 32'd1);
        chk("cd_state1", 32'(state_out), 32'd1);
        tick();
        chk("alarm1_state", 32'(state_out), 32'd6);
        chk("alarm1_remain", 32'(remain), 32'd0);

        // full escalation: 4 ticks per level, MISSED on tick 12
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("esc_tick%0d", k), 32'(state_out),
                (k < 4) ? 32'd6 : (k < 8) ? 32'd7 : (k < 12) ? 32'd8 : 32'd9);
        end
        chk("missed_cnt1", 32'(missed_cnt), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("hold_miss%0d", k), 32'(state_out), 32'd9);
        end
        tick();
        chk("rearm_state", 32'(state_out), 32'd1);
        chk("rearm_remain", 32'(remain), 32'd3);

        // ack together with tick in ALARM_2
        repeat (3) tick();
        chk("a1_again", 32'(state_out), 32'd6);
        repeat (4) tick();
        chk("a2_enter", 32'(state_out), 32'd7);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("ack_tick_state", 32'(state_out), 32'd2);
        chk("ack_tick_taken", 32'(taken_cnt), 32'd1);
        repeat (4) tick();
        chk("hold_taken4", 32'(state_out), 32'd2);
        tick();
        chk("taken_exit_state", 32'(state_out), 32'd1);
        chk("taken_exit_remain", 32'(remain), 32'd3);

        // cancel beats ack in ALARM_1
        repeat (3) tick();
        chk("a1_pre_cancel", 32'(state_out), 32'd6);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk("cancel_state", 32'(state_out), 32'd0);
        chk("cancel_taken", 32'(taken_cnt), 32'd1);
        chk("cancel_remain", 32'(remain), 32'd0);
        chk("cancel_missed", 32'(missed_cnt), 32'd1);
        interval = 16'd0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("arm_zero_ign", 32'(state_out), 32'd0);

        // ack in MISSED exits at once without touching counters
        interval = 16'd1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("arm1_remain", 32'(remain), 32'd1);
        tick();
        repeat (12) tick();
        chk("miss2_state", 32'(state_out), 32'd9);
        chk("miss2_cnt", 32'(missed_cnt), 32'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("miss_ack_state", 32'(state_out), 32'd1);
        chk("miss_ack_remain", 32'(remain), 32'd1);
        chk("miss_ack_taken", 32'(taken_cnt), 32'd1);

        // drive taken_cnt to 255, then one more ack must saturate
        for (int n = 0; n < 254; n++) begin
            tick();
            step(1'b0, 1'b0, 1'b1, 1'b0);
            repeat (5) tick();
        end
        chk("taken_255", 32'(taken_cnt), 32'd255);
        chk("sat_state", 32'(state_out), 32'd1);
        tick();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("taken_sat", 32'(taken_cnt), 32'd255);
        chk("taken_sat_state", 32'(state_out), 32'd2);

        // asynchronous reset takes effect between clock edges
        #2 rst_n = 0;
        #1;
        chk("async_rst_state", 32'(state_out), 32'd0);
        chk("async_rst_taken", 32'(taken_cnt), 32'd0);
        chk("async_rst_missed", 32'(missed_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
